// File: rtl/smi_pkg.sv
// -----------------------------------------------------------------------------
// smi_pkg
// Shared definitions for the SMI receive arbiter slice:
//   - FSM state encoding (legacy-compatible 2-bit constants)
//   - channel identifiers CH_09 / CH_24
//   - test-pattern LFSR seed and its step function
// No ports (package).
// -----------------------------------------------------------------------------
package smi_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULL  = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_SERVE = 2'd3;

    localparam logic CH_09 = 1'b0;
    localparam logic CH_24 = 1'b1;

    localparam logic [7:0] LFSR_SEED = 8'h56;

    // One LFSR step; the all-zero state is a lock-up point, so it is replaced
    // by the seed as soon as it would be reached.
    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        logic [7:0] nxt;
        nxt = {cur[2] ^ cur[3], cur[7:1]};
        if (nxt == 8'h00) begin
            nxt = LFSR_SEED;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/smi_rx_arbiter_if.sv
// -----------------------------------------------------------------------------
// smi_rx_arbiter_if
// Bundles the FIFO-side and SMI-side signals of smi_rx_arbiter.
//   slave  modport : the arbiter (consumes i_*, drives o_*)
//   master modport : the surrounding FIFOs / SMI logic
// Signals:
//   i_enable                      arbitration enable
//   i_fifo_09_empty/_24_empty     FIFO empty flags
//   i_fifo_09_data/_24_data       FIFO read data (valid one cycle after pull)
//   o_fifo_09_pull/_24_pull       one-cycle FIFO pop strobes
//   i_byte_rd                     one strobe per byte consumed by SMI
//   o_smi_data_out                byte presented to SMI
//   o_data_valid                  o_smi_data_out holds an unconsumed byte
//   o_channel                     granted channel (0 = 09, 1 = 24)
//   o_read_req                    data pending
//   o_underrun                    sticky: byte read with no valid data
//   i_test_mode                   only when SMI_RX_TEST_PATTERN_EN is defined
// -----------------------------------------------------------------------------
interface smi_rx_arbiter_if;

`ifdef SMI_RX_TEST_PATTERN_EN
    logic        i_test_mode;
`endif
    logic        i_enable;
    logic        i_fifo_09_empty;
    logic        i_fifo_24_empty;
    logic [31:0] i_fifo_09_data;
    logic [31:0] i_fifo_24_data;
    logic        o_fifo_09_pull;
    logic        o_fifo_24_pull;
    logic        i_byte_rd;
    logic [7:0]  o_smi_data_out;
    logic        o_data_valid;
    logic        o_channel;
    logic        o_read_req;
    logic        o_underrun;

    modport slave (
`ifdef SMI_RX_TEST_PATTERN_EN
        input  i_test_mode,
`endif
        input  i_enable,
        input  i_fifo_09_empty,
        input  i_fifo_24_empty,
        input  i_fifo_09_data,
        input  i_fifo_24_data,
        output o_fifo_09_pull,
        output o_fifo_24_pull,
        input  i_byte_rd,
        output o_smi_data_out,
        output o_data_valid,
        output o_channel,
        output o_read_req,
        output o_underrun
    );

    modport master (
`ifdef SMI_RX_TEST_PATTERN_EN
        output i_test_mode,
`endif
        output i_enable,
        output i_fifo_09_empty,
        output i_fifo_24_empty,
        output i_fifo_09_data,
        output i_fifo_24_data,
        input  o_fifo_09_pull,
        input  o_fifo_24_pull,
        output i_byte_rd,
        input  o_smi_data_out,
        input  o_data_valid,
        input  o_channel,
        input  o_read_req,
        input  o_underrun
    );

endinterface

// File: rtl/smi_word_serializer.sv
// -----------------------------------------------------------------------------
// smi_word_serializer
// Holds one 32-bit word and hands it out one byte at a time, MSB byte first.
// Ports:
//   i_sys_clk      system clock
//   soe_and_reset  asynchronous active-low reset
//   i_load         capture i_word, restart at byte 0, mark valid
//   i_word         word to capture
//   i_advance      consume the current byte (ignored while not valid)
//   o_byte         current byte, 0x00 while not valid
//   o_last_byte    current byte is byte 3 of the word
//   o_valid        a byte is waiting to be consumed
// -----------------------------------------------------------------------------
module smi_word_serializer (
    input  logic        i_sys_clk,
    input  logic        soe_and_reset,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic        i_advance,
    output logic [7:0]  o_byte,
    output logic        o_last_byte,
    output logic        o_valid
);

    logic [31:0] shreg_q, shreg_d;
    logic [1:0]  idx_q,   idx_d;
    logic        valid_q, valid_d;
    logic [7:0]  byte_sel;

    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (i_load) begin
            shreg_d = i_word;
            idx_d   = 2'd0;
            valid_d = 1'b1;
        end else if (i_advance && valid_q) begin
            // 2-bit index wraps 3 -> 0 naturally; the word is finished there.
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        case (idx_q)
            2'd0:    byte_sel = shreg_q[31:24];
            2'd1:    byte_sel = shreg_q[23:16];
            2'd2:    byte_sel = shreg_q[15:8];
            default: byte_sel = shreg_q[7:0];
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge soe_and_reset) begin
        if (!soe_and_reset) begin
            shreg_q <= 32'h0;
            idx_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign o_byte      = valid_q ? byte_sel : 8'h00;
    assign o_last_byte = (idx_q == 2'd3);
    assign o_valid     = valid_q;

endmodule

// File: rtl/smi_rx_arbiter.sv
// -----------------------------------------------------------------------------
// smi_rx_arbiter
// Round-robin arbiter between two 32-bit receive FIFOs (channel 09 and 24)
// feeding a byte-wide SMI read port. A grant serves up to BURST_WORDS words
// before the channels are re-arbitrated.
// Parameters:
//   BURST_WORDS    words per grant, 1..256
// Ports:
//   i_sys_clk      system clock
//   soe_and_reset  asynchronous active-low reset
//   bus            smi_rx_arbiter_if.slave (FIFO and SMI side signals)
// Build option:
//   SMI_RX_TEST_PATTERN_EN  adds bus.i_test_mode; when set, bytes come from an
//                           8-bit LFSR instead of the FIFOs.
// -----------------------------------------------------------------------------
module smi_rx_arbiter
    import smi_pkg::*;
#(
    parameter int BURST_WORDS = 16
) (
    input  logic            i_sys_clk,
    input  logic            soe_and_reset,
    smi_rx_arbiter_if.slave bus
);

    localparam logic [7:0] LAST_WCNT = 8'(BURST_WORDS - 1);

    logic [1:0] state_q,    state_d;
    logic       grant_q,    grant_d;
    logic       last_q,     last_d;
    logic [7:0] wcnt_q,     wcnt_d;
    logic       underrun_q, underrun_d;

    logic        pull_09;
    logic        pull_24;
    logic        ser_load;
    logic [31:0] ser_word;
    logic        ser_advance;
    logic [7:0]  ser_byte;
    logic        ser_last;
    logic        ser_valid;
    logic        granted_empty;
    logic        any_ready;
    logic        test_act;
    logic        data_valid;
    logic [7:0]  data_out;

`ifdef SMI_RX_TEST_PATTERN_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Gated by reset so every output reads 0 while reset is held.
    assign test_act = bus.i_test_mode & soe_and_reset;

    always_comb begin
        lfsr_d = lfsr_q;
        if (test_act && bus.i_byte_rd) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge i_sys_clk or negedge soe_and_reset) begin
        if (!soe_and_reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign data_out = test_act ? lfsr_q : ser_byte;
`else
    assign test_act = 1'b0;
    assign data_out = ser_byte;
`endif

    assign granted_empty = (grant_q == CH_24) ? bus.i_fifo_24_empty : bus.i_fifo_09_empty;
    assign any_ready     = ~bus.i_fifo_09_empty | ~bus.i_fifo_24_empty;
    assign ser_word      = (grant_q == CH_24) ? bus.i_fifo_24_data : bus.i_fifo_09_data;
    assign ser_advance   = (state_q == ST_SERVE) & bus.i_byte_rd & ser_valid & ~test_act;
    assign data_valid    = test_act | ser_valid;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        wcnt_d   = wcnt_q;
        pull_09  = 1'b0;
        pull_24  = 1'b0;
        ser_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_enable && any_ready && !test_act) begin
                    // Both ready: the channel not served last wins. last_q
                    // comes out of reset as CH_24 so channel 09 goes first.
                    if (!bus.i_fifo_09_empty && !bus.i_fifo_24_empty) begin
                        grant_d = ~last_q;
                    end else if (!bus.i_fifo_09_empty) begin
                        grant_d = CH_09;
                    end else begin
                        grant_d = CH_24;
                    end
                    last_d  = grant_d;
                    state_d = ST_PULL;
                end
            end
            ST_PULL: begin
                // A FIFO drained behind our back leaves nothing to load, so
                // fall back to IDLE instead of capturing stale data.
                if (!granted_empty && !test_act) begin
                    pull_09 = (grant_q == CH_09);
                    pull_24 = (grant_q == CH_24);
                    state_d = ST_LOAD;
                end else begin
                    wcnt_d  = 8'd0;
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // FIFO read data is valid this cycle, one after the pull.
                ser_load = 1'b1;
                state_d  = ST_SERVE;
            end
            ST_SERVE: begin
                if (ser_advance && ser_last) begin
                    if (wcnt_q == LAST_WCNT || granted_empty || !bus.i_enable) begin
                        wcnt_d  = 8'd0;
                        state_d = ST_IDLE;
                    end else begin
                        wcnt_d  = wcnt_q + 8'd1;
                        state_d = ST_PULL;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        underrun_d = underrun_q | (bus.i_byte_rd & ~data_valid);
    end

    always_ff @(posedge i_sys_clk or negedge soe_and_reset) begin
        if (!soe_and_reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= CH_09;
            last_q     <= CH_24;
            wcnt_q     <= 8'd0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            wcnt_q     <= wcnt_d;
            underrun_q <= underrun_d;
        end
    end

    smi_word_serializer u_serializer (
        .i_sys_clk     (i_sys_clk),
        .soe_and_reset (soe_and_reset),
        .i_load        (ser_load),
        .i_word        (ser_word),
        .i_advance     (ser_advance),
        .o_byte        (ser_byte),
        .o_last_byte   (ser_last),
        .o_valid       (ser_valid)
    );

    assign bus.o_fifo_09_pull = pull_09;
    assign bus.o_fifo_24_pull = pull_24;
    assign bus.o_smi_data_out = data_out;
    assign bus.o_data_valid   = data_valid;
    assign bus.o_channel      = grant_q;
    // FIFO flags are combinational inputs, so reset is folded in to keep the
    // request low while reset is held.
    assign bus.o_read_req     = soe_and_reset &
                                (data_valid | ~bus.i_fifo_09_empty | ~bus.i_fifo_24_empty);
    assign bus.o_underrun     = underrun_q;

endmodule

// File: tb/tb_smi_rx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_smi_rx_arbiter
// Bench for smi_rx_arbiter: two instances (BURST_WORDS 2 and 16) fed by
// behavioural FIFOs. Expected bytes/channels go into a queue as words are
// queued and are popped as the SMI side consumes bytes.
// -----------------------------------------------------------------------------
module tb_smi_rx_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic sel;   // 0: BURST_WORDS=2 instance, 1: BURST_WORDS=16 instance
    logic rd;
    logic en;
    logic tm;

    smi_rx_arbiter_if bus2 ();
    smi_rx_arbiter_if bus16 ();

    smi_rx_arbiter #(.BURST_WORDS(2)) u_dut2 (
        .i_sys_clk     (clk),
        .soe_and_reset (rst_n),
        .bus           (bus2)
    );

    smi_rx_arbiter #(.BURST_WORDS(16)) u_dut16 (
        .i_sys_clk     (clk),
        .soe_and_reset (rst_n),
        .bus           (bus16)
    );

    // FIFO models: 0 = inst2/09, 1 = inst2/24, 2 = inst16/09, 3 = inst16/24
    logic [31:0] mem [4][64];
    int          wp [4];
    int          rp [4] = '{0, 0, 0, 0};
    logic [31:0] dq [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    int          pcnt [4] = '{0, 0, 0, 0};
    int          bad_both  = 0;
    int          bad_empty = 0;
    logic [3:0]  pull;
    logic [3:0]  empt;

    assign pull = {bus16.o_fifo_24_pull, bus16.o_fifo_09_pull,
                   bus2.o_fifo_24_pull,  bus2.o_fifo_09_pull};
    assign empt[0] = (rp[0] == wp[0]);
    assign empt[1] = (rp[1] == wp[1]);
    assign empt[2] = (rp[2] == wp[2]);
    assign empt[3] = (rp[3] == wp[3]);

    assign bus2.i_enable        = en;
    assign bus16.i_enable       = en;
    assign bus2.i_byte_rd       = rd & ~sel;
    assign bus16.i_byte_rd      = rd & sel;
    assign bus2.i_fifo_09_empty = empt[0];
    assign bus2.i_fifo_24_empty = empt[1];
    assign bus16.i_fifo_09_empty = empt[2];
    assign bus16.i_fifo_24_empty = empt[3];
    assign bus2.i_fifo_09_data  = dq[0];
    assign bus2.i_fifo_24_data  = dq[1];
    assign bus16.i_fifo_09_data = dq[2];
    assign bus16.i_fifo_24_data = dq[3];
`ifdef SMI_RX_TEST_PATTERN_EN
    assign bus2.i_test_mode  = tm;
    assign bus16.i_test_mode = 1'b0;
`endif

    always @(posedge clk) begin
        if ((pull[0] && pull[1]) || (pull[2] && pull[3])) begin
            bad_both <= bad_both + 1;
        end
        for (int k = 0; k < 4; k++) begin
            if (pull[k]) begin
                if (empt[k]) begin
                    bad_empty <= bad_empty + 1;
                end else begin
                    dq[k]   <= mem[k][rp[k] % 64];
                    rp[k]   <= rp[k] + 1;
                    pcnt[k] <= pcnt[k] + 1;
                end
            end
        end
    end

    // Selected-instance view of the outputs
    logic       s_valid, s_ch, s_req, s_urun;
    logic [7:0] s_data;
    assign s_valid = sel ? bus16.o_data_valid   : bus2.o_data_valid;
    assign s_data  = sel ? bus16.o_smi_data_out : bus2.o_smi_data_out;
    assign s_ch    = sel ? bus16.o_channel      : bus2.o_channel;
    assign s_req   = sel ? bus16.o_read_req     : bus2.o_read_req;
    assign s_urun  = sel ? bus16.o_underrun     : bus2.o_underrun;

    typedef struct packed {
        logic [7:0] b;
        logic       ch;
    } exp_t;
    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_fifo(input int k, input logic [31:0] w);
        mem[k][wp[k] % 64] = w;
        wp[k] = wp[k] + 1;
    endtask

    task automatic exp_byte(input logic [7:0] b, input logic ch);
        exp_t e;
        e.b  = b;
        e.ch = ch;
        exp_q.push_back(e);
    endtask

    task automatic exp_word(input logic [31:0] w, input logic ch);
        exp_byte(w[31:24], ch);
        exp_byte(w[23:16], ch);
        exp_byte(w[15:8],  ch);
        exp_byte(w[7:0],   ch);
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (s_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Consume n bytes, comparing each against the scoreboard.
    task automatic drain(input int n);
        bit   ok;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            wait_valid(40, ok);
            if (!ok) begin
                check_val("valid_timeout", 32'(s_valid), 32'd1);
                break;
            end
            if (exp_q.size() == 0) begin
                check_val("scoreboard_empty", 32'(exp_q.size()), 32'd1);
                break;
            end
            e = exp_q.pop_front();
            check_val("byte", 32'(s_data), 32'(e.b));
            check_val("chan", 32'(s_ch), 32'(e.ch));
            rd = 1'b1;
            @(negedge clk);
            rd = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rd    = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [7:0] pat_next(input logic [7:0] v);
        logic [7:0] n;
        n = (v >> 1) | (8'(v[2] ^ v[3]) << 7);
        if (n == 8'h00) n = 8'h56;
        return n;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  p0, p1, lat;
        bit  got;
        for (int k = 0; k < 4; k++) wp[k] = 0;
        sel = 1'b0;
        rd  = 1'b0;
        en  = 1'b1;
        tm  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_val("rst_valid", 32'(s_valid), 32'd0);
        check_val("rst_data",  32'(s_data),  32'd0);
        check_val("rst_chan",  32'(s_ch),    32'd0);
        check_val("rst_req",   32'(s_req),   32'd0);
        check_val("rst_urun",  32'(s_urun),  32'd0);
        check_val("rst_pull",  32'(pull),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Byte read while idle: sticky underrun, data stays 0
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        check_val("urun_set",  32'(s_urun), 32'd1);
        check_val("urun_data", 32'(s_data), 32'd0);
        repeat (5) @(negedge clk);
        check_val("urun_sticky", 32'(s_urun),  32'd1);
        check_val("urun_valid",  32'(s_valid), 32'd0);
        do_reset();
        check_val("urun_cleared", 32'(s_urun), 32'd0);

        // Single word from FIFO 09, pull-to-valid latency
        p0 = pcnt[0];
        p1 = pcnt[1];
        push_fifo(0, 32'hA1B2C3D4);
        exp_word(32'hA1B2C3D4, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (bus2.o_fifo_09_pull) got = 1'b1;
            else @(negedge clk);
        end
        check_val("pull09_seen", 32'(got), 32'd1);
        lat = 0;
        while (!s_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_val("pull_to_valid", 32'(lat), 32'd2);
        drain(4);
        repeat (4) @(negedge clk);
        check_val("single_idle_valid", 32'(s_valid), 32'd0);
        check_val("single_idle_req",   32'(s_req),   32'd0);
        check_val("single_pulls09",    32'(pcnt[0] - p0), 32'd1);
        check_val("single_pulls24",    32'(pcnt[1] - p1), 32'd0);

        // Enable low holds the arbiter in IDLE
        do_reset();
        en = 1'b0;
        p0 = pcnt[0];
        push_fifo(0, 32'hCAFEF00D);
        repeat (6) @(negedge clk);
        check_val("dis_nopull", 32'(pcnt[0] - p0), 32'd0);
        check_val("dis_req",    32'(s_req),   32'd1);
        check_val("dis_valid",  32'(s_valid), 32'd0);
        en = 1'b1;
        exp_word(32'hCAFEF00D, 1'b0);
        drain(4);

        // Reset mid-word discards the partial word and restores 09-first
        do_reset();
        push_fifo(0, 32'h11223344);
        push_fifo(0, 32'h55667788);
        push_fifo(1, 32'h99AABBCC);
        exp_byte(8'h11, 1'b0);
        exp_byte(8'h22, 1'b0);
        drain(2);
        rst_n = 1'b0;
        #1;
        check_val("midrst_valid", 32'(s_valid), 32'd0);
        check_val("midrst_data",  32'(s_data),  32'd0);
        check_val("midrst_req",   32'(s_req),   32'd0);
        check_val("midrst_chan",  32'(s_ch),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_word(32'h55667788, 1'b0);
        exp_word(32'h99AABBCC, 1'b1);
        drain(8);

        // Round-robin with BURST_WORDS=2: 09, 09, 24, 24, 09
        do_reset();
        push_fifo(0, 32'h09000001);
        push_fifo(0, 32'h09000002);
        push_fifo(0, 32'h09000003);
        push_fifo(1, 32'h24000001);
        push_fifo(1, 32'h24000002);
        exp_word(32'h09000001, 1'b0);
        exp_word(32'h09000002, 1'b0);
        exp_word(32'h24000001, 1'b1);
        exp_word(32'h24000002, 1'b1);
        exp_word(32'h09000003, 1'b0);
        drain(20);

        // BURST_WORDS=16, FIFO 24 runs dry after 3 words
        sel = 1'b1;
        do_reset();
        p0 = pcnt[2];
        p1 = pcnt[3];
        push_fifo(3, 32'hDEAD0001);
        push_fifo(3, 32'hBEEF0002);
        push_fifo(3, 32'h5A5A0003);
        exp_word(32'hDEAD0001, 1'b1);
        exp_word(32'hBEEF0002, 1'b1);
        exp_word(32'h5A5A0003, 1'b1);
        drain(12);
        repeat (6) @(negedge clk);
        check_val("dry_pulls24", 32'(pcnt[3] - p1), 32'd3);
        check_val("dry_pulls09", 32'(pcnt[2] - p0), 32'd0);
        check_val("dry_valid",   32'(s_valid), 32'd0);
        check_val("dry_req",     32'(s_req),   32'd0);
        sel = 1'b0;

`ifdef SMI_RX_TEST_PATTERN_EN
        begin
            logic [7:0] pat;
            do_reset();
            p0 = pcnt[0];
            p1 = pcnt[1];
            tm = 1'b1;
            @(negedge clk);
            pat = 8'h56;
            for (int i = 0; i < 8; i++) begin
                check_val("tm_valid", 32'(s_valid), 32'd1);
                check_val("tm_req",   32'(s_req),   32'd1);
                check_val("tm_byte",  32'(s_data),  32'(pat));
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
                pat = pat_next(pat);
            end
            check_val("tm_nopull", 32'((pcnt[0] - p0) + (pcnt[1] - p1)), 32'd0);
            tm = 1'b0;
        end
`endif

        check_val("never_both_pulls", 32'(bad_both),  32'd0);
        check_val("never_pull_empty", 32'(bad_empty), 32'd0);
        check_val("scoreboard_left",  32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
